// File: rtl/biu_pkg.sv
// Shared types for the BIU request path: request record and queue FSM states.
package biu_pkg;

    localparam int unsigned BIU_ADDR_WIDTH = 32;
    localparam int unsigned BIU_DATA_WIDTH = 32;

    typedef struct packed {
        logic [BIU_ADDR_WIDTH-1:0] addr;
        logic [BIU_DATA_WIDTH-1:0] data;
        logic                      rnw;
    } biu_req_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } biu_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH circular FIFO; pointers carry one extra wrap bit.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/biu_request_queue.sv
// Queues producer bus requests and issues them one at a time to biu_master,
// returning read data with a one-cycle valid pulse.
module biu_request_queue
    import biu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    input  logic                  i_req_rnw,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_overflow,
    input  logic                  i_ovf_clr,
    output logic [ADDR_WIDTH-1:0] o_biu_address,
    output logic [DATA_WIDTH-1:0] o_biu_data_out,
    output logic                  o_biu_rnw,
    output logic                  o_biu_en,
    input  logic                  i_biu_busy,
    input  logic [DATA_WIDTH-1:0] i_biu_data_in,
    output logic                  o_idle
);

    localparam int unsigned REQ_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  rnw;
    } req_t;

    req_t             wr_req;
    req_t             head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push;
    logic             pop;
    biu_state_t       state_q;
    biu_state_t       state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;

    assign wr_req      = '{addr: i_req_addr, data: i_req_data, rnw: i_req_rnw};
    assign push        = i_req_valid & ~full;
    assign o_req_ready = ~full;
    assign o_biu_en    = (state_q == ISSUE);
    assign count_nxt   = count + CNT_W'(push) - CNT_W'(pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_req),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !i_biu_busy) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            // Counter must sit at BUSY_TIMEOUT for one evaluation before giving up.
            WAIT_BUSY: begin
                if (i_biu_busy)                          state_d = WAIT_DONE;
                else if (tmo_q == TMO_W'(BUSY_TIMEOUT))  state_d = COMPLETE;
                else                                     tmo_d   = tmo_q + 1'b1;
            end
            WAIT_DONE: begin
                if (!i_biu_busy) state_d = COMPLETE;
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            tmo_q          <= '0;
            o_biu_address  <= '0;
            o_biu_data_out <= '0;
            o_biu_rnw      <= 1'b0;
            o_rd_valid     <= 1'b0;
            o_rd_data      <= '0;
            o_overflow     <= 1'b0;
            o_idle         <= 1'b1;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            o_rd_valid <= (state_q == COMPLETE) && o_biu_rnw;
            o_idle     <= (count_nxt == '0) && (state_d == IDLE);
            if (pop) begin
                o_biu_address  <= head.addr;
                o_biu_data_out <= head.data;
                o_biu_rnw      <= head.rnw;
            end
            if ((state_q == COMPLETE) && o_biu_rnw) o_rd_data <= i_biu_data_in;
            if (i_ovf_clr)                        o_overflow <= 1'b0;
            else if (i_req_valid && full)         o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_biu_request_queue.sv
// Directed bench for biu_request_queue with a simple biu_master busy model.
module tb_biu_request_queue;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_data = '0;
    logic        i_req_rnw = 1'b0;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_overflow;
    logic        i_ovf_clr = 1'b0;
    logic [31:0] o_biu_address;
    logic [31:0] o_biu_data_out;
    logic        o_biu_rnw;
    logic        o_biu_en;
    logic        i_biu_busy;
    logic [31:0] i_biu_data_in = '0;
    logic        o_idle;

    logic        hold_busy = 1'b0;
    logic        model_busy = 1'b0;
    int unsigned model_len = 0;
    logic [31:0] model_rdata = '0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [64:0] req;
        int          cyc;
    } ent_t;
    ent_t        log_q[$];
    logic [64:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rnw;
        int unsigned busy_len;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[6];

    assign i_biu_busy = hold_busy | model_busy;

    biu_request_queue #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .DEPTH        (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_data     (i_req_data),
        .i_req_rnw      (i_req_rnw),
        .o_rd_valid     (o_rd_valid),
        .o_rd_data      (o_rd_data),
        .o_overflow     (o_overflow),
        .i_ovf_clr      (i_ovf_clr),
        .o_biu_address  (o_biu_address),
        .o_biu_data_out (o_biu_data_out),
        .o_biu_rnw      (o_biu_rnw),
        .o_biu_en       (o_biu_en),
        .i_biu_busy     (i_biu_busy),
        .i_biu_data_in  (i_biu_data_in),
        .o_idle         (o_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_biu_en) log_q.push_back('{req: {o_biu_address, o_biu_data_out, o_biu_rnw}, cyc: cyc});
    end

    // BIU model: busy rises the cycle after en and lasts model_len cycles;
    // read data appears when busy falls (or at en when busy never rises).
    always begin
        @(negedge clk);
        if (o_biu_en) begin
            if (model_len > 0) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (model_len) @(posedge clk);
                #1 model_busy = 1'b0;
            end
            i_biu_data_in = model_rdata;
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic r, input bit accept);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_data  = d;
        i_req_rnw   = r;
        if (accept) exp_q.push_back({a, d, r});
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic push_when_ready(input logic [31:0] a, input logic [31:0] d, input logic r);
        int unsigned waited = 0;
        @(negedge clk);
        while (!o_req_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!o_req_ready) check("ready_timeout", 96'(o_req_ready), 96'd1);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_data  = d;
        i_req_rnw   = r;
        exp_q.push_back({a, d, r});
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int unsigned bound);
        int unsigned n = 0;
        @(negedge clk);
        while (!o_idle && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 96'(o_idle), 96'd1);
    endtask

    task automatic drain_compare(input string name, input int unsigned bound);
        int unsigned n;
        wait_idle({name, "_idle"}, bound);
        check({name, "_count"}, 96'(log_q.size()), 96'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) check({name, "_order"}, 96'(log_q[i].req), 96'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] exp_rd_data = '0;
        int unsigned rd_pulses;
        logic [31:0] rd_seen;

        vecs[0] = '{addr: 32'hC000_0000, data: 32'h1234_1234, rnw: 1'b0, busy_len: 3, rdata: 32'h0};
        vecs[1] = '{addr: 32'hC000_0004, data: 32'h0000_0000, rnw: 1'b1, busy_len: 2, rdata: 32'hDEAD_BEEF};
        vecs[2] = '{addr: 32'h0000_0010, data: 32'hAAAA_5555, rnw: 1'b0, busy_len: 1, rdata: 32'h1111_1111};
        vecs[3] = '{addr: 32'h0000_0020, data: 32'h0000_0000, rnw: 1'b1, busy_len: 5, rdata: 32'h1357_9BDF};
        vecs[4] = '{addr: 32'hFFFF_FFFC, data: 32'hFFFF_FFFF, rnw: 1'b0, busy_len: 0, rdata: 32'h2222_2222};
        vecs[5] = '{addr: 32'h0000_0000, data: 32'h0000_0000, rnw: 1'b1, busy_len: 0, rdata: 32'h0BAD_F00D};

        repeat (3) @(negedge clk);
        check("rst_ready", 96'(o_req_ready), 96'd1);
        check("rst_idle", 96'(o_idle), 96'd1);
        check("rst_en", 96'(o_biu_en), 96'd0);
        check("rst_outs", {o_biu_address, o_biu_data_out, 31'd0, o_biu_rnw}, 96'd0);
        check("rst_rd", {31'd0, o_rd_valid, o_rd_data, 31'd0, o_overflow}, 96'd0);
        n_rst = 1'b1;

        // Single-request vectors: latency, en width, issued fields, read response.
        for (int unsigned v = 0; v < 6; v++) begin
            model_len     = vecs[v].busy_len;
            model_rdata   = vecs[v].rdata;
            i_biu_data_in = '0;
            push_req(vecs[v].addr, vecs[v].data, vecs[v].rnw, 1'b0);
            @(negedge clk);
            check("en_pre", 96'(o_biu_en), 96'd0);
            @(negedge clk);
            check("en_issue", 96'(o_biu_en), 96'd1);
            check("issue_fields", {o_biu_address, o_biu_data_out, 31'd0, o_biu_rnw},
                  {vecs[v].addr, vecs[v].data, 31'd0, vecs[v].rnw});
            @(negedge clk);
            check("en_width", 96'(o_biu_en), 96'd0);
            rd_pulses = 0;
            rd_seen   = '0;
            for (int unsigned n = 0; n < 40 && !o_idle; n++) begin
                @(negedge clk);
                if (o_rd_valid) begin
                    rd_pulses++;
                    rd_seen = o_rd_data;
                end
            end
            check("vec_idle", 96'(o_idle), 96'd1);
            check("rd_pulses", 96'(rd_pulses), 96'(vecs[v].rnw));
            if (vecs[v].rnw) begin
                exp_rd_data = vecs[v].rdata;
                check("rd_data_pulse", 96'(rd_seen), 96'(exp_rd_data));
            end
            repeat (2) @(negedge clk);
            check("rd_data_held", 96'(o_rd_data), 96'(exp_rd_data));
            log_q.delete();
        end

        // Fill with busy held, overflow on the fifth, then drain in order.
        model_len = 1;
        hold_busy = 1'b1;
        for (int unsigned i = 0; i < 4; i++) push_req(32'h100 + 32'(i), 32'hF0 + 32'(i), 1'b0, 1'b1);
        check("full_ready", 96'(o_req_ready), 96'd0);
        check("no_ovf_yet", 96'(o_overflow), 96'd0);
        push_req(32'h1FF, 32'hBAD, 1'b0, 1'b0);
        check("ovf_set", 96'(o_overflow), 96'd1);
        @(negedge clk);
        hold_busy = 1'b0;
        drain_compare("fill_drain", 100);
        check("ovf_sticky", 96'(o_overflow), 96'd1);
        @(negedge clk);
        i_ovf_clr = 1'b1;
        @(posedge clk);
        #1 i_ovf_clr = 1'b0;
        check("ovf_clr", 96'(o_overflow), 96'd0);

        // Busy never rises: second issue exactly BUSY_TIMEOUT+4 cycles after the first.
        model_len = 0;
        push_req(32'h200, 32'h1, 1'b0, 1'b1);
        push_req(32'h204, 32'h2, 1'b0, 1'b1);
        wait_idle("tmo_idle", 60);
        check("tmo_issues", 96'(log_q.size()), 96'd2);
        if (log_q.size() == 2) check("tmo_spacing", 96'(log_q[1].cyc - log_q[0].cyc), 96'd8);
        log_q.delete();
        exp_q.delete();

        // Push and pop on the same edge at count 2 leaves count 2.
        hold_busy = 1'b1;
        push_req(32'h300, 32'h30, 1'b0, 1'b1);
        push_req(32'h304, 32'h31, 1'b0, 1'b1);
        @(negedge clk);
        hold_busy   = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h308;
        i_req_data  = 32'h32;
        i_req_rnw   = 1'b0;
        exp_q.push_back({32'h308, 32'h32, 1'b0});
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        push_req(32'h30C, 32'h33, 1'b0, 1'b1);
        check("cnt3_ready", 96'(o_req_ready), 96'd1);
        push_req(32'h310, 32'h34, 1'b0, 1'b1);
        check("cnt4_ready", 96'(o_req_ready), 96'd0);
        // Clear beats a simultaneous overflow set.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_ovf_clr   = 1'b1;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        i_ovf_clr = 1'b0;
        check("clr_wins", 96'(o_overflow), 96'd0);
        drain_compare("pushpop_drain", 200);

        // Wrap the pointers more than three times; order must hold.
        model_len = 1;
        for (int unsigned i = 0; i < 26; i++)
            push_when_ready(32'h1000 + 32'(i * 4), 32'hA500_0000 + 32'(i), 1'(i % 2));
        drain_compare("wrap_drain", 300);

        // Reset while in WAIT_DONE with three requests queued.
        model_len = 0;
        push_req(32'h400, 32'h40, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        hold_busy = 1'b1;
        for (int unsigned i = 1; i < 4; i++) push_req(32'h400 + 32'(i * 4), 32'h40 + 32'(i), 1'b0, 1'b0);
        check("pre_rst_busy", 96'(o_idle), 96'd0);
        #2 n_rst = 1'b0;
        #1;
        check("rst2_en", 96'(o_biu_en), 96'd0);
        check("rst2_idle", 96'(o_idle), 96'd1);
        check("rst2_ready", 96'(o_req_ready), 96'd1);
        @(negedge clk);
        n_rst = 1'b1;
        log_q.delete();
        repeat (3) @(negedge clk);
        hold_busy = 1'b0;
        repeat (15) @(negedge clk);
        check("no_stale_issue", 96'(log_q.size()), 96'd0);
        check("rst2_idle_after", 96'(o_idle), 96'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
